// File: rtl/parking_lot_if.sv
// Sensor inputs and occupancy/event outputs of the parking lot controller.
// The master drives the gate sensors; the slave is the controller.
interface parking_lot_if #(
   parameter int unsigned CAPACITY = 99
);
   localparam int unsigned COUNT_W = $clog2(CAPACITY + 1);

   logic               sensor_a_i;
   logic               sensor_b_i;
   logic [COUNT_W-1:0] occupancy_o;
   logic               full_o;
   logic               empty_o;
   logic               enter_o;
   logic               exit_o;
   logic               overflow_o;
   logic               underflow_o;
   logic               seq_err_o;

   modport master (
      output sensor_a_i, sensor_b_i,
      input  occupancy_o, full_o, empty_o, enter_o, exit_o,
             overflow_o, underflow_o, seq_err_o
   );

   modport slave (
      input  sensor_a_i, sensor_b_i,
      output occupancy_o, full_o, empty_o, enter_o, exit_o,
             overflow_o, underflow_o, seq_err_o
   );
endinterface

// File: rtl/parking_lot_controller.sv
// Decodes outer/inner beam order into entries and exits and keeps a
// saturating occupancy count with full/empty flags and event pulses.
module parking_lot_controller #(
   parameter int unsigned CAPACITY = 99
) (
   input logic          clk_i,
   input logic          rst_i,
   parking_lot_if.slave bus
);
   localparam int unsigned COUNT_W = $clog2(CAPACITY + 1);

   typedef enum logic [2:0] {
      IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A
   } state_t;

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] occ_q, occ_d;
   logic               enter_q, exit_q, over_q, under_q, err_q;
   logic               enter_d, exit_d, over_d, under_d, err_d;
   logic [1:0]         ab;

   assign ab = {bus.sensor_a_i, bus.sensor_b_i};

   // State, count and pulse registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         occ_q   <= '0;
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
         over_q  <= 1'b0;
         under_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         enter_q <= enter_d;
         exit_q  <= exit_d;
         over_q  <= over_d;
         under_q <= under_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      occ_d   = occ_q;
      enter_d = 1'b0;
      exit_d  = 1'b0;
      over_d  = 1'b0;
      under_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ab == 2'b10)      state_d = EN_A;
            else if (ab == 2'b01) state_d = EX_B;
         end
         EN_A: begin
            unique case (ab)
               2'b11:   state_d = EN_AB;
               2'b00:   state_d = IDLE;
               2'b01: begin state_d = IDLE; err_d = 1'b1; end
               default: state_d = EN_A;
            endcase
         end
         EN_AB: begin
            unique case (ab)
               2'b01:   state_d = EN_B;
               2'b10:   state_d = EN_A;
               2'b00: begin state_d = IDLE; err_d = 1'b1; end
               default: state_d = EN_AB;
            endcase
         end
         EN_B: begin
            unique case (ab)
               2'b11:   state_d = EN_AB;
               2'b10: begin state_d = IDLE; err_d = 1'b1; end
               2'b00: begin
                  state_d = IDLE;
                  // Saturate at CAPACITY: report overflow instead of counting
                  if (occ_q < COUNT_W'(CAPACITY)) begin
                     occ_d   = occ_q + COUNT_W'(1);
                     enter_d = 1'b1;
                  end else begin
                     over_d = 1'b1;
                  end
               end
               default: state_d = EN_B;
            endcase
         end
         EX_B: begin
            unique case (ab)
               2'b11:   state_d = EX_BA;
               2'b00:   state_d = IDLE;
               2'b10: begin state_d = IDLE; err_d = 1'b1; end
               default: state_d = EX_B;
            endcase
         end
         EX_BA: begin
            unique case (ab)
               2'b10:   state_d = EX_A;
               2'b01:   state_d = EX_B;
               2'b00: begin state_d = IDLE; err_d = 1'b1; end
               default: state_d = EX_BA;
            endcase
         end
         EX_A: begin
            unique case (ab)
               2'b11:   state_d = EX_BA;
               2'b01: begin state_d = IDLE; err_d = 1'b1; end
               2'b00: begin
                  state_d = IDLE;
                  if (occ_q != '0) begin
                     occ_d  = occ_q - COUNT_W'(1);
                     exit_d = 1'b1;
                  end else begin
                     under_d = 1'b1;
                  end
               end
               default: state_d = EX_A;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.occupancy_o = occ_q;
   assign bus.full_o      = (occ_q == COUNT_W'(CAPACITY));
   assign bus.empty_o     = (occ_q == '0);
   assign bus.enter_o     = enter_q;
   assign bus.exit_o      = exit_q;
   assign bus.overflow_o  = over_q;
   assign bus.underflow_o = under_q;
   assign bus.seq_err_o   = err_q;
endmodule
